// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, a one-entry hold buffer for
// responses that land while downstream is stalled, and redirect-driven flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipeline_stop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_req_pc, w_req_pc_nxt;
  logic [31:0] r_hold_pc, w_hold_pc_nxt;
  logic [31:0] r_hold_inst, w_hold_inst_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic [31:0] r_if_inst, w_if_inst_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic        w_out_free;
  logic        w_unused;

  assign w_unused   = ^redirect_pc[1:0];
  assign w_out_free = !r_if_valid || !pipeline_stop;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_pc_nxt    = r_req_pc;
    w_hold_pc_nxt   = r_hold_pc;
    w_hold_inst_nxt = r_hold_inst;
    // Presented instruction is held only while stalled; otherwise it is consumed.
    if (r_if_valid && pipeline_stop) begin
      w_if_pc_nxt    = r_if_pc;
      w_if_inst_nxt  = r_if_inst;
      w_if_valid_nxt = r_if_valid;
    end else begin
      w_if_pc_nxt    = 32'h0;
      w_if_inst_nxt  = 32'h0;
      w_if_valid_nxt = 1'b0;
    end

    if (redirect_valid) begin
      w_pc_nxt        = {redirect_pc[31:2], 2'b00};
      w_if_pc_nxt     = 32'h0;
      w_if_inst_nxt   = 32'h0;
      w_if_valid_nxt  = 1'b0;
      w_hold_pc_nxt   = 32'h0;
      w_hold_inst_nxt = 32'h0;
      // A response arriving in the redirect cycle itself is the one being dropped,
      // so there is nothing left to wait for.
      case (r_state)
        REQ:       w_state_nxt = imem_gnt ? DROP : REQ;
        WAIT, DROP: w_state_nxt = imem_rvalid ? REQ : DROP;
        default:   w_state_nxt = REQ;
      endcase
    end else begin
      case (r_state)
        REQ: begin
          if (imem_gnt) begin
            w_state_nxt  = WAIT;
            w_req_pc_nxt = r_pc;
            w_pc_nxt     = r_pc + 32'd4;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (w_out_free) begin
              w_if_pc_nxt    = r_req_pc;
              w_if_inst_nxt  = imem_rdata;
              w_if_valid_nxt = 1'b1;
              w_state_nxt    = REQ;
            end else begin
              w_hold_pc_nxt   = r_req_pc;
              w_hold_inst_nxt = imem_rdata;
              w_state_nxt     = HOLD;
            end
          end
        end
        HOLD: begin
          if (!pipeline_stop) begin
            w_if_pc_nxt    = r_hold_pc;
            w_if_inst_nxt  = r_hold_inst;
            w_if_valid_nxt = 1'b1;
            w_state_nxt    = REQ;
          end
        end
        default: begin
          if (imem_rvalid) w_state_nxt = REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= REQ;
      r_pc        <= RESET_PC;
      r_req_pc    <= 32'h0;
      r_hold_pc   <= 32'h0;
      r_hold_inst <= 32'h0;
      r_if_pc     <= 32'h0;
      r_if_inst   <= 32'h0;
      r_if_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_hold_pc   <= w_hold_pc_nxt;
      r_hold_inst <= w_hold_inst_nxt;
      r_if_pc     <= w_if_pc_nxt;
      r_if_inst   <= w_if_inst_nxt;
      r_if_valid  <= w_if_valid_nxt;
    end
  end

  assign imem_req  = (r_state == REQ);
  assign imem_addr = r_pc;
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;
  assign if_valid  = r_if_valid;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 pipeline_stop  input  1  SHALL mean the downstream stage is stalled and the current if_* outputs are not consumed.
REQ-005 redirect_valid  input  1  SHALL mean a branch, jump or exception redirect is requested this cycle.
REQ-006 redirect_pc  input  32  SHALL be the redirect target address.
REQ-007 imem_req  output  1  SHALL mean an instruction read request is presented.
REQ-008 imem_addr  output  32  SHALL be the word-aligned request address.
REQ-009 imem_gnt  input  1  SHALL mean the memory has accepted the request this cycle.
REQ-010 imem_rvalid  input  1  SHALL mean read data is returned this cycle, always at least one cycle after its grant.
REQ-011 imem_rdata  input  32  SHALL be the returned instruction.
REQ-012 if_pc  output  32  SHALL be the registered PC of the presented instruction.
REQ-013 if_inst  output  32  SHALL be the registered presented instruction.
REQ-014 if_valid  output  1  SHALL mean if_pc/if_inst hold a real instruction; when low, if_pc = if_inst = 0 (bubble).

Function
REQ-015 State machine states SHALL be REQ, WAIT, HOLD and DROP, with at most one outstanding memory request.
REQ-016 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc_q; in all other states imem_req SHALL be 0.
REQ-017 In REQ, imem_addr SHALL stay stable until imem_gnt, except on a redirect.
REQ-018 REQ with imem_gnt (no redirect) SHALL go to WAIT, set pc_q <= pc_q + 4 (32-bit modulo; 32'hFFFF_FFFC wraps to 0), and save the granted address as req_pc.
REQ-019 Output-free condition: out_free = !if_valid || !pipeline_stop.
REQ-020 WAIT with imem_rvalid and out_free SHALL load if_pc <= req_pc, if_inst <= imem_rdata, if_valid <= 1 next cycle, and go to REQ.
REQ-021 WAIT with imem_rvalid and !out_free SHALL capture {req_pc, imem_rdata} in a one-entry hold buffer and go to HOLD.
REQ-022 HOLD with !pipeline_stop SHALL move the hold buffer to the outputs (if_valid <= 1) and go to REQ; otherwise it SHALL stay in HOLD.
REQ-023 While pipeline_stop=1 and if_valid=1, if_pc, if_inst and if_valid SHALL hold their values.
REQ-024 When if_valid=1, pipeline_stop=0 and no new instruction loads this cycle, the next cycle SHALL be a bubble (if_valid=0, if_pc=0, if_inst=0).
REQ-025 Redirect SHALL have highest priority over pipeline_stop, grant and rvalid.
REQ-026 On redirect, pc_q <= {redirect_pc[31:2], 2'b00}.
REQ-027 On redirect, the outputs SHALL go to bubble next cycle and the hold buffer SHALL be discarded.
REQ-028 Redirect from WAIT, or from REQ with imem_gnt in the same cycle, SHALL go to DROP.
REQ-029 Redirect from REQ without grant, or from HOLD, SHALL go to REQ.
REQ-030 DROP with imem_rvalid SHALL discard the data and go to REQ; a further redirect in DROP SHALL only update pc_q.
REQ-031 Sustained throughput SHALL be one instruction per (grant latency + response latency + 1) cycles; no speculative second request is issued.

Reset
REQ-032 On rst_n=0, asynchronously: state=REQ, pc_q=RESET_PC, req_pc=0, hold buffer cleared, if_pc=0, if_inst=0, if_valid=0.
REQ-033 While rst_n=0, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-034 Reset asserted mid-transaction SHALL abandon any outstanding request; a late imem_rvalid after reset release while in REQ SHALL be ignored.

Verification
REQ-035 Reset release, gnt immediate, rvalid one cycle later with rdata=32'h0000_0013 -> imem_addr=0, then if_pc=0, if_inst=32'h13, if_valid=1; next request at addr 4.
REQ-036 pipeline_stop=1 held 3 cycles while a second response (addr 4, rdata=32'hAAAA_AAAA) arrives -> outputs keep addr 0 data; HOLD entered; addr 4 data presented the cycle after stop drops; no request issued during HOLD.
REQ-037 redirect_valid=1, redirect_pc=32'h0000_0103 while in WAIT -> DROP; returned data discarded; if_valid=0; next imem_addr=32'h0000_0100.
REQ-038 redirect_valid and pipeline_stop both 1 while if_valid=1 -> next cycle if_valid=0, if_pc=0, if_inst=0.
REQ-039 pc_q=32'hFFFF_FFFC granted -> next imem_addr=32'h0000_0000.
REQ-040 imem_gnt withheld 4 cycles -> imem_req=1 and imem_addr stable throughout; if_valid bubbles after the last instruction is consumed.
